// File: rtl/aes_in_packer.sv
// aes_in_packer: packs a 32-bit word stream into 128-bit blocks for the AES
// encrypt datapath, owns the encryptor key register, and tracks blocks in
// flight so a key change can never land in the middle of an operation.
module aes_in_packer #(
  parameter int LAT     = 3,
  parameter int KEY_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_ready,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         flush,
  output logic [127:0] aes_in,
  output logic [127:0] aes_key,
  output logic         blk_issue,
  output logic         out_valid,
  output logic [1:0]   inflight
);

  localparam int SW = (KEY_LAT < 1) ? 1 : $clog2(KEY_LAT + 1);

  logic [127:0]   shadow;
  logic [1:0]     word_cnt;
  logic [SW-1:0]  settle;
  logic           key_loaded;
  logic [LAT-1:0] vld_sr;
  logic           accept;
  logic           key_accept;

  // Key changes only when nothing is partially packed, pending or in flight.
  assign key_ready  = (word_cnt == 2'd0) && !blk_issue && (inflight == 2'd0) &&
                      (vld_sr == '0);
  assign key_accept = key_load && key_ready;
  assign s_ready    = key_loaded && (settle == '0) && !flush;
  assign accept     = s_valid && s_ready;
  assign out_valid  = vld_sr[LAT-1];

  // Key register and post-load settle timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_key    <= '0;
      key_loaded <= 1'b0;
      settle     <= '0;
    end else if (key_accept) begin
      aes_key    <= key_in;
      key_loaded <= 1'b1;
      settle     <= SW'(KEY_LAT);
    end else if (settle != '0) begin
      settle <= settle - 1'b1;
    end
  end

  // Word packing into the shadow register; aes_in only changes on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      word_cnt  <= 2'd0;
      aes_in    <= '0;
      blk_issue <= 1'b0;
    end else begin
      blk_issue <= 1'b0;
      if (flush) begin
        shadow   <= '0;
        word_cnt <= 2'd0;
      end else if (accept) begin
        case (word_cnt)
          2'd0: shadow[127:96] <= s_data;
          2'd1: shadow[95:64]  <= s_data;
          2'd2: shadow[63:32]  <= s_data;
          default: begin
            // Last word bypasses the shadow so the block issues next cycle.
            aes_in    <= {shadow[127:32], s_data};
            blk_issue <= 1'b1;
            shadow    <= '0;
          end
        endcase
        word_cnt <= word_cnt + 2'd1;
      end
    end
  end

  // Delay line that mirrors the encryptor pipeline latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[LAT-2:0], blk_issue};
    end
  end

  // Count of issued blocks whose ciphertext has not yet appeared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 2'd0;
    end else begin
      case ({blk_issue, out_valid})
        2'b10:   if (inflight != 2'(LAT)) inflight <= inflight + 2'd1;
        2'b01:   if (inflight != 2'd0)    inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_in_packer.sv
// Directed, table-driven bench for aes_in_packer.
module tb_aes_in_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         key_ready;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         flush = 1'b0;
  logic [127:0] aes_in;
  logic [127:0] aes_key;
  logic         blk_issue;
  logic         out_valid;
  logic [1:0]   inflight;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PA = 128'ha0000000a0000001a0000002a0000003;
  localparam logic [127:0] PB = 128'hb0000000b0000001b0000002b0000003;
  localparam logic [127:0] PD = 128'hd0000000d0000001d0000002d0000003;

  aes_in_packer #(.LAT(3), .KEY_LAT(2)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .key_ready(key_ready), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .aes_in(aes_in), .aes_key(aes_key),
    .blk_issue(blk_issue), .out_valid(out_valid), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sv;
    logic [31:0]  data;
    logic         fl;
    logic         kl;
    logic [127:0] kin;
    logic         sr;
    logic         bi;
    logic         ov;
    logic [1:0]   inf;
    logic         kr;
    logic [127:0] ain;
    logic [127:0] akey;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sv, input logic [31:0] data, input logic fl,
                     input logic kl, input logic [127:0] kin, input logic sr,
                     input logic bi, input logic ov, input logic [1:0] inf,
                     input logic kr, input logic [127:0] ain,
                     input logic [127:0] akey);
    vec_t v;
    v.sv = sv; v.data = data; v.fl = fl; v.kl = kl; v.kin = kin;
    v.sr = sr; v.bi = bi; v.ov = ov; v.inf = inf; v.kr = kr;
    v.ain = ain; v.akey = akey;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // row: sv data fl kl kin | sr bi ov inf kr | aes_in aes_key
    add(0, 0, 0, 1, K1,            0, 0, 0, 0, 1, 0,  0);   // 0 key load
    add(0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0,  K1);  // 1 settle
    add(0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0,  K1);  // 2 settle
    add(1, 32'h00112233, 0, 0, 0,  1, 0, 0, 0, 1, 0,  K1);  // 3
    add(1, 32'h44556677, 0, 0, 0,  1, 0, 0, 0, 0, 0,  K1);  // 4
    add(1, 32'h8899aabb, 0, 0, 0,  1, 0, 0, 0, 0, 0,  K1);  // 5
    add(1, 32'hccddeeff, 0, 0, 0,  1, 0, 0, 0, 0, 0,  K1);  // 6
    add(1, 32'ha0000000, 0, 0, 0,  1, 1, 0, 0, 0, P1, K1);  // 7 issue P1
    add(1, 32'ha0000001, 0, 0, 0,  1, 0, 0, 1, 0, P1, K1);  // 8
    add(1, 32'ha0000002, 0, 0, 0,  1, 0, 0, 1, 0, P1, K1);  // 9
    add(1, 32'ha0000003, 0, 0, 0,  1, 0, 1, 1, 0, P1, K1);  // 10 out P1
    add(1, 32'hb0000000, 0, 0, 0,  1, 1, 0, 0, 0, PA, K1);  // 11 issue PA
    add(1, 32'hb0000001, 0, 0, 0,  1, 0, 0, 1, 0, PA, K1);  // 12
    add(1, 32'hb0000002, 0, 0, 0,  1, 0, 0, 1, 0, PA, K1);  // 13
    add(1, 32'hb0000003, 0, 0, 0,  1, 0, 1, 1, 0, PA, K1);  // 14 out PA
    add(0, 0, 0, 0, 0,             1, 1, 0, 0, 0, PB, K1);  // 15 issue PB
    add(0, 0, 0, 0, 0,             1, 0, 0, 1, 0, PB, K1);  // 16
    add(0, 0, 0, 0, 0,             1, 0, 0, 1, 0, PB, K1);  // 17
    add(0, 0, 0, 0, 0,             1, 0, 1, 1, 0, PB, K1);  // 18 out PB
    add(0, 0, 0, 0, 0,             1, 0, 0, 0, 1, PB, K1);  // 19 drained
    add(1, 32'hc0000000, 0, 0, 0,  1, 0, 0, 0, 1, PB, K1);  // 20
    add(1, 32'hc0000001, 0, 0, 0,  1, 0, 0, 0, 0, PB, K1);  // 21
    add(1, 32'hdeadbeef, 1, 1, K2, 0, 0, 0, 0, 0, PB, K1);  // 22 flush, key ignored
    add(1, 32'hd0000000, 0, 0, 0,  1, 0, 0, 0, 1, PB, K1);  // 23
    add(1, 32'hd0000001, 0, 0, 0,  1, 0, 0, 0, 0, PB, K1);  // 24
    add(1, 32'hd0000002, 0, 0, 0,  1, 0, 0, 0, 0, PB, K1);  // 25
    add(1, 32'hd0000003, 0, 0, 0,  1, 0, 0, 0, 0, PB, K1);  // 26
    add(0, 0, 0, 0, 0,             1, 1, 0, 0, 0, PD, K1);  // 27 issue PD
    add(0, 0, 0, 1, K2,            1, 0, 0, 1, 0, PD, K1);  // 28 key ignored
    add(0, 0, 0, 0, 0,             1, 0, 0, 1, 0, PD, K1);  // 29
    add(0, 0, 0, 0, 0,             1, 0, 1, 1, 0, PD, K1);  // 30 out PD
    add(0, 0, 0, 1, K2,            1, 0, 0, 0, 1, PD, K1);  // 31 key accepted
    add(0, 0, 0, 0, 0,             0, 0, 0, 0, 1, PD, K2);  // 32 settle
    add(0, 0, 0, 0, 0,             0, 0, 0, 0, 1, PD, K2);  // 33 settle
    add(0, 0, 0, 0, 0,             1, 0, 0, 0, 1, PD, K2);  // 34

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_s_ready",   -1, 128'(s_ready),   128'(0));
    chk("rst_key_ready", -1, 128'(key_ready), 128'(1));
    chk("rst_blk_issue", -1, 128'(blk_issue), 128'(0));
    chk("rst_out_valid", -1, 128'(out_valid), 128'(0));
    chk("rst_inflight",  -1, 128'(inflight),  128'(0));
    chk("rst_aes_in",    -1, aes_in,  128'(0));
    chk("rst_aes_key",   -1, aes_key, 128'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      s_valid = vecs[i].sv; s_data = vecs[i].data; flush = vecs[i].fl;
      key_load = vecs[i].kl; key_in = vecs[i].kin;
      #1;
      chk("s_ready",   i, 128'(s_ready),   128'(vecs[i].sr));
      chk("blk_issue", i, 128'(blk_issue), 128'(vecs[i].bi));
      chk("out_valid", i, 128'(out_valid), 128'(vecs[i].ov));
      chk("inflight",  i, 128'(inflight),  128'(vecs[i].inf));
      chk("key_ready", i, 128'(key_ready), 128'(vecs[i].kr));
      chk("aes_in",    i, aes_in,  vecs[i].ain);
      chk("aes_key",   i, aes_key, vecs[i].akey);
      step();
    end
    s_valid = 0; flush = 0; key_load = 0; key_in = '0;

    // Async reset mid-block with one block in flight.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'he0000000 + 32'(i);
      step();
    end
    s_valid = 1'b0;
    chk("ar_issue", 100, 128'(blk_issue), 128'(1));
    chk("ar_aes_in", 100, aes_in, 128'he0000000e0000001e0000002e0000003);
    s_valid = 1'b1; s_data = 32'hf0000000;
    step();
    chk("ar_inflight", 101, 128'(inflight), 128'(1));
    s_data = 32'hf0000001;
    step();
    #3 rst = 1'b1;
    #1;
    chk("ar_aes_in0",    102, aes_in, 128'(0));
    chk("ar_aes_key0",   102, aes_key, 128'(0));
    chk("ar_blk_issue0", 102, 128'(blk_issue), 128'(0));
    chk("ar_out_valid0", 102, 128'(out_valid), 128'(0));
    chk("ar_inflight0",  102, 128'(inflight), 128'(0));
    chk("ar_s_ready0",   102, 128'(s_ready), 128'(0));
    chk("ar_key_ready1", 102, 128'(key_ready), 128'(1));
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ar_no_out_valid", 110 + i, 128'(out_valid), 128'(0));
      chk("ar_no_s_ready",   110 + i, 128'(s_ready), 128'(0));
    end
    s_valid = 1'b0;
    key_load = 1'b1; key_in = K2;
    #1 chk("rk_key_ready", 120, 128'(key_ready), 128'(1));
    step();
    key_load = 1'b0; key_in = '0;
    chk("rk_aes_key", 121, aes_key, K2);
    chk("rk_s_ready_a", 121, 128'(s_ready), 128'(0));
    step();
    chk("rk_s_ready_b", 122, 128'(s_ready), 128'(0));
    step();
    chk("rk_s_ready_c", 123, 128'(s_ready), 128'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes_in_packer.md
Name: aes_in_packer

Overview:
- Upstream feeder for the 128-bit AES encrypt datapath.
- Accepts a 32-bit word stream with valid/ready, packs 4 words into one 128-bit block, and drives the encryptor's block and key inputs.
- Generates a delayed valid aligned to the encryptor's registered output.
- Gates key changes so no in-flight block is ever processed under a mixed key schedule.

Parameters:
- LAT, 3, cycles from block issue (aes_in valid) to encryptor output valid.
- KEY_LAT, 2, settle cycles after a key load before the first block may be accepted.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- key_in  input  128  cipher key
- key_load  input  1  request to latch key_in
- key_ready  output  1  key_load will be accepted this cycle
- s_data  input  32  input word
- s_valid  input  1  s_data valid
- s_ready  output  1  word accepted when s_valid && s_ready
- flush  input  1  discard any partially packed block
- aes_in  output  128  block to encryptor data input
- aes_key  output  128  key to encryptor key input
- blk_issue  output  1  one-cycle pulse: aes_in holds a new block this cycle
- out_valid  output  1  encryptor output is a valid ciphertext this cycle
- inflight  output  2  blocks issued but not yet out_valid (0..LAT)

Behaviour:
- Reset (async, immediate) clears all registers:
  - aes_in=0, aes_key=0, blk_issue=0, out_valid=0, inflight=0.
  - word_cnt=0, settle=0, key_loaded=0.
  - After reset: s_ready=0, key_ready=1.
- Key handling:
  - key_ready = (word_cnt==0) && !blk_issue && (inflight==0) && (valid shift register all zero).
  - key_load && key_ready: aes_key <= key_in; key_loaded <= 1; settle <= KEY_LAT.
  - key_load while !key_ready: ignored; aes_key is unchanged.
  - settle decrements by 1 per cycle down to 0.
- s_ready = key_loaded && (settle==0) && !flush.
  - Words are accepted every cycle with no bubble between blocks.
- Packing:
  - Word k of a block (k=0..3) is written to aes_in bits [127-32k -: 32]; the first word goes into the MSBs.
  - Packing uses a shadow register, and aes_in updates only on issue.
  - On acceptance of word 3, next cycle: aes_in <= packed block, blk_issue=1 for exactly one cycle, word_cnt wraps 3->0.
  - aes_in holds its value between issues.
- Issue rate: at most one block per 4 cycles. Back-to-back full-rate streaming issues every 4th cycle.
- Valid tracking:
  - LAT-bit shift register, bit 0 loaded with blk_issue.
  - out_valid = bit LAT-1, so a block issued in cycle T gives out_valid in cycle T+LAT.
- inflight counter:
  - +1 on blk_issue, -1 on out_valid.
  - Simultaneous increment and decrement: no change.
  - Never exceeds LAT.
- flush:
  - Clears word_cnt and the shadow register in the same cycle.
  - A word presented with flush is dropped (s_ready=0).
  - Does not cancel a pending blk_issue or in-flight blocks.
  - A flush in the issue cycle has no effect on that issue.
- No backpressure from the encryptor: it has no stall, so out_valid is purely a delay of blk_issue.
- key_load is not accepted while flush-free packing is mid-block (word_cnt!=0). The caller must flush first.

Test Plan:
- Reset then key_load with key_in=000102030405060708090a0b0c0d0e0f → key_ready=1, aes_key updates next cycle; s_ready low for 2 cycles, then 1.
- Stream 00112233, 44556677, 8899aabb, ccddeeff on 4 consecutive cycles → next cycle aes_in=00112233445566778899aabbccddeeff with blk_issue=1; out_valid exactly 3 cycles later, and encryptor output then equals 69c4e0d86a7b0430d8cdb78070b4c55a.
- Stream 8 words continuously → two blk_issue pulses 4 cycles apart, two out_valid pulses 4 cycles apart; inflight peaks at 1, returns to 0.
- Send 2 words, assert flush with s_valid=1, then send 4 new words → single issue containing only the 4 new words; the flushed-cycle word is absent.
- key_load asserted while inflight=1 or word_cnt=2 → ignored, aes_key unchanged; retried after drain → accepted.
- Assert rst asynchronously mid-block with inflight=1 → all outputs 0 immediately, no later out_valid, s_ready=0 until a new key_load.
